// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state type and address helpers for the LCD bus responder
package lcd_pkg;

   localparam logic [7:0] OP_CLEAR   = 8'h01;
   localparam logic [7:0] OP_HOME    = 8'h02;
   localparam logic [7:0] OP_ENTRY   = 8'h04;
   localparam logic [7:0] OP_DISPCTL = 8'h08;
   localparam logic [7:0] OP_SHIFT   = 8'h10;
   localparam logic [7:0] OP_FUNC    = 8'h20;
   localparam logic [7:0] OP_CGADDR  = 8'h40;
   localparam logic [7:0] OP_DDADDR  = 8'h80;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE1_LAST = 7'h27;
   localparam logic [6:0] LINE2_LAST = 7'h67;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } resp_state_t;

   // DDRAM cursor step with the two-line wrap between 0x27/0x40 and 0x67/0x00
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
      logic [6:0] n;
      if (inc) begin
         if (a == LINE1_LAST)      n = LINE2_BASE;
         else if (a == LINE2_LAST) n = LINE1_BASE;
         else                      n = a + 7'd1;
      end else begin
         if (a == LINE1_BASE)      n = LINE2_LAST;
         else if (a == LINE2_BASE) n = LINE1_LAST;
         else                      n = a - 7'd1;
      end
      return n;
   endfunction

   function automatic logic addr_visible(input logic [6:0] a);
      return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
   endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// rtl/lcd_strobe_sync.sv - bus input synchronizer and lcd_e falling-edge detector
module lcd_strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       strobe,
   output logic       rs,
   output logic       rw,
   output logic [7:0] data
);

   // All bus bits share one chain so rs/rw/data line up with the detected edge
   logic [10:0] r_sync [SYNC_STAGES];
   logic        r_e_prev;
   logic [10:0] w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_e_prev <= 1'b0;
      end else begin
         r_sync[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_e_prev <= r_sync[SYNC_STAGES-1][10];
      end
   end

   assign w_last = r_sync[SYNC_STAGES-1];
   assign strobe = r_e_prev && !w_last[10];
   assign rs     = w_last[9];
   assign rw     = w_last[8];
   assign data   = w_last[7:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-style bus responder with 2x16 character buffer
module lcd_bus_responder
   import lcd_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_CHAR   = 8'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [6:0] cursor_addr,
   output logic       init_done,
   output logic       two_line,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       entry_shift,
   output logic       busy,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic       wr_valid,
   output logic       oor,
   output logic       err
);

   logic        w_strobe, w_rs, w_rw;
   logic [7:0]  w_data;

   resp_state_t r_state, w_next_state;
   logic [4:0]  r_clr_idx;
   logic [7:0]  r_buf [32];
   logic [7:0]  r_rd_char;
   logic [6:0]  r_cursor;
   logic        r_cg_mode;
   logic        r_init_done, r_two_line, r_disp_on, r_cursor_on, r_blink_on;
   logic        r_entry_inc, r_entry_shift;
   logic        r_cmd_valid, r_wr_valid, r_oor, r_err;
   logic [7:0]  r_cmd_code;

   logic        w_accept, w_cmd, w_dat, w_reject, w_store;
   logic [4:0]  w_idx;

   lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data),
      .strobe   (w_strobe),
      .rs       (w_rs),
      .rw       (w_rw),
      .data     (w_data)
   );

   assign w_accept = w_strobe && (r_state == ST_IDLE) && !w_rw;
   assign w_cmd    = w_accept && !w_rs;
   assign w_dat    = w_accept && w_rs;
   assign w_reject = w_strobe && ((r_state == ST_CLEAR) || w_rw);
   assign w_store  = w_dat && !r_cg_mode && addr_visible(r_cursor);
   assign w_idx    = {r_cursor[6], r_cursor[3:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_cmd && (w_data == OP_CLEAR)) w_next_state = ST_CLEAR;
         ST_CLEAR: if (r_clr_idx == 5'd31)            w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clr_idx     <= '0;
         r_cursor      <= LINE1_BASE;
         r_cg_mode     <= 1'b0;
         r_init_done   <= 1'b0;
         r_two_line    <= 1'b0;
         r_disp_on     <= 1'b0;
         r_cursor_on   <= 1'b0;
         r_blink_on    <= 1'b0;
         r_entry_inc   <= 1'b1;
         r_entry_shift <= 1'b0;
         r_cmd_valid   <= 1'b0;
         r_cmd_code    <= '0;
         r_wr_valid    <= 1'b0;
         r_oor         <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_cmd_valid <= w_cmd;
         r_wr_valid  <= w_store;
         r_oor       <= w_dat && !w_store;
         r_err       <= w_reject;
         if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 5'd1;
         if (w_cmd) begin
            r_cmd_code <= w_data;
            // Priority decode on the highest set bit of the instruction byte
            casez (w_data)
               8'b1???????: begin
                  r_cg_mode <= 1'b0;
                  r_cursor  <= w_data[6:0];
               end
               8'b01??????: r_cg_mode <= 1'b1;
               8'b001?????: begin
                  r_two_line <= w_data[3];
                  if (w_data[4]) r_init_done <= 1'b1;
               end
               8'b0001????: if (!w_data[3]) r_cursor <= step_addr(r_cursor, w_data[2]);
               8'b00001???: begin
                  r_disp_on   <= w_data[2];
                  r_cursor_on <= w_data[1];
                  r_blink_on  <= w_data[0];
               end
               8'b000001??: begin
                  r_entry_inc   <= w_data[1];
                  r_entry_shift <= w_data[0];
               end
               8'b0000001?: r_cursor <= LINE1_BASE;
               8'b00000001: begin
                  r_cursor    <= LINE1_BASE;
                  r_entry_inc <= 1'b1;
                  r_cg_mode   <= 1'b0;
                  r_clr_idx   <= '0;
               end
               default: ;
            endcase
         end
         if (w_dat && !r_cg_mode) r_cursor <= step_addr(r_cursor, r_entry_inc);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) r_buf[i] <= FILL_CHAR;
         r_rd_char <= '0;
      end else begin
         if (r_state == ST_CLEAR) r_buf[r_clr_idx] <= FILL_CHAR;
         else if (w_store)        r_buf[w_idx]     <= w_data;
         r_rd_char <= r_buf[rd_addr];
      end
   end

   assign rd_char     = r_rd_char;
   assign cursor_addr = r_cursor;
   assign init_done   = r_init_done;
   assign two_line    = r_two_line;
   assign disp_on     = r_disp_on;
   assign cursor_on   = r_cursor_on;
   assign blink_on    = r_blink_on;
   assign entry_inc   = r_entry_inc;
   assign entry_shift = r_entry_shift;
   assign busy        = (r_state == ST_CLEAR);
   assign cmd_valid   = r_cmd_valid;
   assign cmd_code    = r_cmd_code;
   assign wr_valid    = r_wr_valid;
   assign oor         = r_oor;
   assign err         = r_err;

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Responder end of the HD44780-style character-LCD bus driven by the team's text LCD writer. It samples lcd_e/lcd_rs/lcd_rw/lcd_data in the system clock domain and latches one bus transfer on every falling edge of lcd_e. It decodes the instruction set, maintains cursor address, mode flags and a 2x16 character buffer, and exposes the buffer through a read port. It is used as the on-chip loopback/monitor for the display path and as the checker-side model in the LCD bench.

## Interface
- SYNC_STAGES, 2, synchronizer depth applied to all four bus inputs (minimum 2)
- FILL_CHAR, 8'h20, character written by clear-display
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- lcd_e  in  1  enable strobe; a transfer is latched on its falling edge
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read (unsupported)
- lcd_data  in  8  bus data
- rd_addr  in  5  buffer read index: 0-15 = line 1, 16-31 = line 2
- rd_char  out  8  buffer[rd_addr], registered
- cursor_addr  out  7  current DDRAM address
- init_done  out  1  sticky; set by a function set with DL=1
- two_line, disp_on, cursor_on, blink_on, entry_inc, entry_shift  out  1 each  decoded mode flags
- busy  out  1  clear sweep in progress
- cmd_valid  out  1  one-cycle pulse per accepted instruction
- cmd_code  out  8  last accepted instruction byte
- wr_valid  out  1  one-cycle pulse per data byte stored in the buffer
- oor  out  1  one-cycle pulse: data byte dropped (address outside visible range, or CGRAM mode)
- err  out  1  one-cycle pulse: read transfer, or strobe while busy

## Operation
- Reset values: rd_char 0, cursor_addr 0, init_done 0, two_line 0, disp_on 0, cursor_on 0, blink_on 0, entry_inc 1, entry_shift 0, busy 0, cmd_code 0, all pulses 0, all buffer entries FILL_CHAR.
- States: IDLE, CLEAR (32-cycle fill sweep). A strobe in IDLE with rw=1 raises err and changes nothing else.
- The instruction decode (rs=0) is selected by the highest set bit of lcd_data:
  - 01: enter CLEAR; cursor_addr=0; entry_inc=1; DD mode.
  - 02/03: cursor_addr=0.
  - 04-07: entry_inc=bit1, entry_shift=bit0.
  - 08-0F: disp_on=bit2, cursor_on=bit1, blink_on=bit0.
  - 10-1F: if bit3=0, move the cursor by one (bit2=1 right, otherwise left) using the wrap rule. If bit3=1 (display shift), the instruction is accepted with no effect.
  - 20-3F: two_line=bit3; if bit4=1, set init_done.
  - 40-7F: CG mode; cursor_addr unchanged.
  - 80-FF: DD mode; cursor_addr=data[6:0].
- Data writes (rs=1):
  - Condition for storing: DD mode and cursor_addr in 0x00-0x0F or 0x40-0x4F.
  - When stored, the index is {cursor_addr[6], cursor_addr[3:0]} and wr_valid pulses.
  - Otherwise the byte is dropped and oor pulses.
  - In DD mode, the cursor then moves by one according to entry_inc. In CG mode the cursor does not move.
- Wrap rule: increment 0x27 -> 0x40 and 0x67 -> 0x00. Decrement 0x00 -> 0x67 and 0x40 -> 0x27.
- CLEAR writes FILL_CHAR to index 0..31, one per cycle, then returns to IDLE. Any strobe during CLEAR is dropped and raises err.
- rd_char remains readable during CLEAR and shows the partially cleared contents.

## Timing
- Falling-edge definition: a falling lcd_e is the sampled last synchronizer stage = 0 while the previous sample = 1. rs, rw and data are captured through the same depth on the same cycle.
- A strobe detected at clk edge k updates all state, flags and pulses at edge k+1. With SYNC_STAGES=2, this is three clk edges after the pin falls.
- busy goes high at k+1 and low at k+33. Strobes detected at k+1..k+32 are rejected.
- rd_char has a latency of 1 cycle from rd_addr. A same-cycle write to the addressed index returns the old value.
- A rising lcd_e, or a static lcd_e, has no effect. Back-to-back strobes are legal once the bus idles for 2 cycles between them.
- Reset mid-CLEAR aborts the sweep immediately and restores all reset values, including the full FILL_CHAR buffer.

## Structure
- Package lcd_pkg:
  - instruction opcode/mask constants: CLEAR 8'h01, HOME 8'h02, ENTRY 8'h04, DISPCTL 8'h08, SHIFT 8'h10, FUNC 8'h20, CGADDR 8'h40, DDADDR 8'h80
  - line base addresses 7'h00/7'h40 and wrap limits 7'h27/7'h67
  - responder state enum
- Sub-module lcd_strobe_sync: SYNC_STAGES-deep synchronizer plus the falling-edge detector. It outputs strobe, rs, rw and data[7:0].
- Buffer: 32x8 register array inside the top level.

## Test plan
- Reset released, no strobes -> every output at its reset value; rd_char=8'h20 for all 32 indices.
- Strobe 38, 0C, 06 (rs=0) -> init_done=1, two_line=1, disp_on=1, cursor_on=0, entry_inc=1, three cmd_valid pulses, cmd_code=8'h06.
- Strobe 80, then data 44, 69 -> rd_addr 0 returns 8'h44, rd_addr 1 returns 8'h69, cursor_addr=7'h02, two wr_valid pulses.
- Strobe C0, then 17 data bytes 48.. -> indices 16-31 filled, 17th byte dropped with oor at 7'h50, cursor_addr=7'h51. Then strobe E7 and one data byte -> cursor_addr wraps to 7'h00.
- Strobe 01 -> busy high exactly 32 cycles, all entries 8'h20, cursor_addr=0. A strobe inside the window -> err pulse, state unchanged. Reset asserted mid-sweep -> reset values.
- Strobe with rw=1 -> err pulse only. Strobe 06 then 10 from cursor_addr 7'h40 -> cursor_addr=7'h27.
